clusterv_tile_sram_arbiter: RTL
===============================

Name: clusterv_tile_sram_arbiter

Overview:
Shares one tile-local byte-enable SRAM port (8-bit word address, 32-bit data) between two initiators: port 0 is the tile core, port 1 is the host/DMA loader. Arbitration is round-robin per access, with a lock input that lets an initiator hold the SRAM for multi-word sequences. The block sits between the initiators and the tile SRAM's t_ target port, and returns read data with a valid strobe.

Parameters:
ADR_WIDTH, 8, SRAM word-address width
DAT_WIDTH, 32, SRAM data width; must be a multiple of 8

Ports:
clock  input  1  single clock
reset  input  1  asynchronous, active-high reset
i0_req  input  1  port 0 access request
i0_lock  input  1  port 0 keeps ownership after its grant while high
i0_gnt  output  1  port 0 access performed this cycle
i0_addr  input  ADR_WIDTH  port 0 word address
i0_we  input  1  port 0 write (1) / read (0)
i0_sel  input  DAT_WIDTH/8  port 0 byte enables
i0_wdat  input  DAT_WIDTH  port 0 write data
i0_rdat  output  DAT_WIDTH  port 0 read data
i0_rvalid  output  1  port 0 read data valid
i1_*  same set as i0_*  port 1
t_addr  output  ADR_WIDTH  SRAM address
t_write_en  output  1  SRAM write enable
t_byte_en  output  DAT_WIDTH/8  SRAM byte enables
t_write_data  output  DAT_WIDTH  SRAM write data
t_read_data  input  DAT_WIDTH  SRAM read data, registered, valid 1 cycle after address

Behaviour:
- Handshake: an initiator raises req with its command stable. The command is accepted in the cycle gnt=1; gnt is combinational from req and state. The initiator holds the command until gnt. A new command may be presented in the cycle after gnt.
- At most one gnt per cycle. If neither initiator is granted: t_write_en=0, t_byte_en=0, t_addr=0, t_write_data=0.
- Winner's command drives t_* combinationally in its grant cycle: t_write_en=we, t_byte_en=sel, t_addr=addr, t_write_data=wdat.
- Round-robin: a register last_gnt records the last winner. When both initiators request, the one that is not last_gnt wins. With a single requester, that requester wins. last_gnt updates on every grant.
- Lock: register owner_valid/owner_id.
  - A grant with iN_lock=1 sets owner=N.
  - While owner_valid, only the owner can be granted, and the other initiator waits even if the owner is idle.
  - The owner is released in the first cycle in which the owner's lock is 0. In that same cycle, normal arbitration applies, including to the owner's own request.
- Read return: a granted read (we=0) sets a 1-cycle pipeline register (rd_pend, rd_id). In the next cycle, i{rd_id}_rvalid=1 and i{rd_id}_rdat=t_read_data.
  - The other port's rvalid=0. rdat is don't-care when rvalid=0 (drive t_read_data to both).
  - Back-to-back reads by alternating ports each return exactly one cycle after their own grant.
- Writes produce no rvalid. A write in the cycle after a read does not disturb that read's return.
- Reset (async assert): last_gnt=1, so port 0 wins the first tie. owner_valid=0, rd_pend=0, all rvalid=0.
  - gnt outputs are forced to 0 while reset=1, and t_write_en/t_byte_en are forced to 0.
  - A read granted in the cycle before reset asserts is dropped, with no rvalid.
- Deassertion takes effect on the next clock edge. No grant occurs in any cycle where reset=1.

Decomposition:
- Package clusterv_tile_sram_pkg:
  - ADR/DAT width defaults
  - initiator-id typedef (1 bit)
  - constants INIT_CORE=0, INIT_HOST=1
- Sub-module clusterv_rr_arb2: 2-way round-robin with lock.
  - Inputs: req[1:0], lock[1:0], clock, reset.
  - Outputs: gnt[1:0], gnt_id.
  - Holds last_gnt and owner state.
- The top level holds the command mux and the read-return pipeline.

Test Plan:
- Reset then idle: both rvalid=0, both gnt=0, t_write_en=0, t_byte_en=0 during and after reset.
- Port 0 write addr 0x10 data 0xDEADBEEF sel 0xF, then port 1 read 0x10 -> each gnt in its request cycle; i1_rvalid the next cycle with i1_rdat=0xDEADBEEF; i0_rvalid stays 0.
- Both ports request reads every cycle (addr 0x01 / 0x02) for 6 cycles after reset -> grants alternate 0,1,0,1,0,1; each rvalid follows its grant by 1 cycle with the matching SRAM word.
- Byte-enable write: port 1 writes 0x11223344 sel 0x5 over 0xDEADBEEF at 0x20, then reads -> 0xDE22BE44.
- Lock: port 1 gets a grant with lock=1 while port 0 requests continuously; port 1 does 3 more accesses with an idle gap -> port 0 gets no gnt until the cycle port 1 drops lock; port 0 is then granted (port 1 was last_gnt).
- Reset asserted in the cycle after a granted read -> no rvalid on either port; the first tie after deassertion is granted to port 0.

Source files
------------

// File: rtl/clusterv_tile_sram_pkg.sv
// clusterv_tile_sram_pkg: shared widths, initiator ids for the tile SRAM arbiter
package clusterv_tile_sram_pkg;
  localparam int ADR_W_DEF = 8;
  localparam int DAT_W_DEF = 32;
  typedef logic init_id_t;
  localparam init_id_t INIT_CORE = 1'b0;
  localparam init_id_t INIT_HOST = 1'b1;
endpackage

// File: rtl/clusterv_rr_arb2.sv
// clusterv_rr_arb2: 2-way round-robin arbiter with lock (in: clock, reset, req[1:0], lock[1:0]; out: gnt[1:0], gnt_id)
module clusterv_rr_arb2
  import clusterv_tile_sram_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [1:0] lock,
  output logic [1:0] gnt,
  output init_id_t   gnt_id
);
  init_id_t last_q, last_d, own_id_q, own_id_d;
  logic own_v_q, own_v_d, held;
  always_comb begin
    // ownership lapses in the first cycle the owner's lock is low, and that cycle arbitrates normally
    held = own_v_q && lock[own_id_q];
    gnt = 2'b00;
    if (!reset) begin
      if (held) gnt[own_id_q] = req[own_id_q];
      else if (&req) gnt[~last_q] = 1'b1;
      else gnt = req;
    end
    gnt_id = gnt[1] ? INIT_HOST : INIT_CORE;
    last_d = |gnt ? gnt_id : last_q;
    own_v_d = |gnt ? lock[gnt_id] : held;
    own_id_d = |gnt ? gnt_id : own_id_q;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      last_q <= INIT_HOST;
      own_v_q <= 1'b0;
      own_id_q <= INIT_CORE;
    end else begin
      last_q <= last_d;
      own_v_q <= own_v_d;
      own_id_q <= own_id_d;
    end
endmodule

// File: rtl/clusterv_tile_sram_arbiter.sv
// clusterv_tile_sram_arbiter: shares one byte-enable SRAM port between core (i0) and host (i1)
// ports: iN_req/lock/addr/we/sel/wdat in, iN_gnt/rdat/rvalid out; t_* drive the SRAM, t_read_data returns 1 cycle later
module clusterv_tile_sram_arbiter
  import clusterv_tile_sram_pkg::*;
#(
  parameter int ADR_WIDTH = ADR_W_DEF,
  parameter int DAT_WIDTH = DAT_W_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   i0_req,
  input  logic                   i0_lock,
  output logic                   i0_gnt,
  input  logic [ADR_WIDTH-1:0]   i0_addr,
  input  logic                   i0_we,
  input  logic [DAT_WIDTH/8-1:0] i0_sel,
  input  logic [DAT_WIDTH-1:0]   i0_wdat,
  output logic [DAT_WIDTH-1:0]   i0_rdat,
  output logic                   i0_rvalid,
  input  logic                   i1_req,
  input  logic                   i1_lock,
  output logic                   i1_gnt,
  input  logic [ADR_WIDTH-1:0]   i1_addr,
  input  logic                   i1_we,
  input  logic [DAT_WIDTH/8-1:0] i1_sel,
  input  logic [DAT_WIDTH-1:0]   i1_wdat,
  output logic [DAT_WIDTH-1:0]   i1_rdat,
  output logic                   i1_rvalid,
  output logic [ADR_WIDTH-1:0]   t_addr,
  output logic                   t_write_en,
  output logic [DAT_WIDTH/8-1:0] t_byte_en,
  output logic [DAT_WIDTH-1:0]   t_write_data,
  input  logic [DAT_WIDTH-1:0]   t_read_data
);
  logic [1:0] gnt;
  init_id_t gnt_id, rd_id_q, rd_id_d;
  logic rd_pend_q, rd_pend_d;
  clusterv_rr_arb2 u_arb (
    .clock(clock),
    .reset(reset),
    .req({i1_req, i0_req}),
    .lock({i1_lock, i0_lock}),
    .gnt(gnt),
    .gnt_id(gnt_id)
  );
  assign i0_gnt = gnt[0];
  assign i1_gnt = gnt[1];
  always_comb begin
    t_write_en = gnt[0] ? i0_we : gnt[1] ? i1_we : 1'b0;
    t_byte_en = gnt[0] ? i0_sel : gnt[1] ? i1_sel : '0;
    t_addr = gnt[0] ? i0_addr : gnt[1] ? i1_addr : '0;
    t_write_data = gnt[0] ? i0_wdat : gnt[1] ? i1_wdat : '0;
    rd_pend_d = |gnt && !t_write_en;
    rd_id_d = gnt_id;
  end
  // async clear drops a read granted just before reset
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      rd_pend_q <= 1'b0;
      rd_id_q <= INIT_CORE;
    end else begin
      rd_pend_q <= rd_pend_d;
      rd_id_q <= rd_id_d;
    end
  assign i0_rvalid = rd_pend_q && rd_id_q == INIT_CORE;
  assign i1_rvalid = rd_pend_q && rd_id_q == INIT_HOST;
  assign i0_rdat = t_read_data;
  assign i1_rdat = t_read_data;
endmodule
